setup_cfg_ctrl: RTL and testbench

//  Parametrised setup controller for the electronic lock: authenticates the master password, walks the user through
//  bip enable, bip time, auto-lock time, master password and N_USERS user passwords, then commits all values atomically.

---
 rtl/setup_cfg_ctrl_pkg.sv | 44 ++++
 rtl/setup_entry_dec.sv | 43 ++++
 rtl/setup_cfg_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_setup_cfg_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/setup_cfg_ctrl_pkg.sv
// Shared types and constants for the lock setup controller.
package setup_cfg_ctrl_pkg;

  localparam int unsigned N_DIG  = 20;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned N_BCD  = 6;
  localparam int unsigned TIME_W = 7;
  localparam int unsigned LEN_W  = 5;

  typedef logic [N_DIG-1:0][DIG_W-1:0] senha_pac_t;
  typedef logic [N_BCD-1:0][DIG_W-1:0] bcd_pac_t;

  typedef struct packed {
    logic              bip_status;
    logic [TIME_W-1:0] bip_time;
    logic [TIME_W-1:0] tranca_aut_time;
    senha_pac_t        senha_master;
  } setup_cfg_t;

  localparam logic [DIG_W-1:0] KEY_EMPTY = 4'hF;
  localparam logic [DIG_W-1:0] KEY_HASH  = 4'hE;

  localparam senha_pac_t SENHA_EMPTY      = '1;
  localparam senha_pac_t SENHA_ABORT      = {{(N_DIG-1){KEY_EMPTY}}, KEY_HASH};
  localparam senha_pac_t SETUP_DEF_MASTER = {{(N_DIG-4){KEY_EMPTY}}, 4'h1, 4'h2, 4'h3, 4'h4};

  localparam logic [DIG_W-1:0] STEP_AUTH   = 4'h1;
  localparam logic [DIG_W-1:0] STEP_BIP_EN = 4'h2;
  localparam logic [DIG_W-1:0] STEP_BIP_T  = 4'h3;
  localparam logic [DIG_W-1:0] STEP_TRC_T  = 4'h4;
  localparam logic [DIG_W-1:0] STEP_MASTER = 4'h5;
  localparam logic [DIG_W-1:0] STEP_USER   = 4'h6;
  localparam logic [DIG_W-1:0] STEP_LOCK   = 4'hE;

  // Split a 0..99 value into its BCD tens / ones digits.
  function automatic logic [DIG_W-1:0] bcd_tens(input logic [TIME_W-1:0] v);
    return DIG_W'(v / TIME_W'(10));
  endfunction

  function automatic logic [DIG_W-1:0] bcd_ones(input logic [TIME_W-1:0] v);
    return DIG_W'(v % TIME_W'(10));
  endfunction

endpackage

// File: rtl/setup_entry_dec.sv
// Classifies a keypad entry: empty, abort, well-formed, decimal, length and 2-digit value.
module setup_entry_dec
  import setup_cfg_ctrl_pkg::*;
(
  input  senha_pac_t        digitos_value,
  output logic              is_empty,
  output logic              is_abort,
  output logic              is_wf,
  output logic              is_dec,
  output logic [LEN_W-1:0]  len,
  output logic [TIME_W-1:0] dec_val
);

  logic seen_f;

  assign is_empty = (digitos_value == SENHA_EMPTY);
  assign is_abort = (digitos_value == SENHA_ABORT);

  // Count typed digits; any digit above a gap of empties makes the entry malformed.
  always_comb begin
    seen_f = 1'b0;
    is_wf  = 1'b1;
    is_dec = 1'b1;
    len    = '0;
    for (int i = 0; i < N_DIG; i++) begin
      if (digitos_value[i] == KEY_EMPTY) begin
        seen_f = 1'b1;
      end else begin
        if (seen_f) is_wf = 1'b0;
        if (digitos_value[i] > 4'd9) is_dec = 1'b0;
        len = len + LEN_W'(1);
      end
    end
  end

  // Decimal value of a one- or two-digit entry.
  always_comb begin
    dec_val = TIME_W'(digitos_value[0]);
    if (len == LEN_W'(2))
      dec_val = TIME_W'(digitos_value[1]) * TIME_W'(10) + TIME_W'(digitos_value[0]);
  end

endmodule

// File: rtl/setup_cfg_ctrl.sv
// Setup controller: master auth, guided edit of a shadow config, atomic commit on SAVE.
module setup_cfg_ctrl
  import setup_cfg_ctrl_pkg::*;
#(
  parameter int unsigned N_USERS     = 4,
  parameter int unsigned PW_MIN_LEN  = 4,
  parameter int unsigned T_MIN       = 5,
  parameter int unsigned T_MAX       = 60,
  parameter int unsigned T_DEF       = 5,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 30000,
  parameter int unsigned LOCK_CYC    = 60000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     setup_on,
  input  senha_pac_t               digitos_value,
  input  logic                     digitos_valid,
  output logic                     display_en,
  output bcd_pac_t                 bcd_pac,
  output setup_cfg_t               data_setup_new,
  output senha_pac_t [N_USERS-1:0] senha_user_new,
  output logic                     data_setup_ok,
  output logic                     setup_err,
  output logic                     setup_locked
);

  localparam int unsigned IDX_W   = (N_USERS > 1) ? $clog2(N_USERS) : 1;
  localparam int unsigned TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMR_MAX = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  typedef senha_pac_t [N_USERS-1:0] users_t;

  localparam setup_cfg_t CFG_DEF = '{
    bip_status:      1'b1,
    bip_time:        TIME_W'(T_DEF),
    tranca_aut_time: TIME_W'(T_DEF),
    senha_master:    SETUP_DEF_MASTER
  };
  localparam users_t USERS_DEF = '1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_AUTH, ST_LOCKOUT, ST_BIP_EN, ST_BIP_T, ST_TRC_T, ST_MASTER, ST_USER, ST_SAVE
  } state_t;

  state_t            state_q, state_nx;
  setup_cfg_t        cfg_q, cfg_nx, sh_q, sh_nx;
  users_t            users_q, users_nx, sh_users_q, sh_users_nx;
  logic [IDX_W-1:0]  idx_q, idx_nx;
  logic [TRY_W-1:0]  tries_q, tries_nx;
  logic [TMR_W-1:0]  timer_q, timer_nx;
  logic              ok_q, ok_nx, err_q, err_nx, locked_q, locked_nx;
  logic              disp_en_q, disp_en_nx;
  bcd_pac_t          bcd_q, bcd_nx;
  logic              discard;

  logic              is_empty, is_abort, is_wf, is_dec;
  logic [LEN_W-1:0]  len;
  logic [TIME_W-1:0] dec_val;
  logic              time_ok, pw_ok;

  setup_entry_dec u_dec (
    .digitos_value (digitos_value),
    .is_empty      (is_empty),
    .is_abort      (is_abort),
    .is_wf         (is_wf),
    .is_dec        (is_dec),
    .len           (len),
    .dec_val       (dec_val)
  );

  assign time_ok = is_wf && is_dec && (len >= LEN_W'(1)) && (len <= LEN_W'(2));
  assign pw_ok   = is_wf && (len >= LEN_W'(PW_MIN_LEN));

  // Out-of-range times fall back to the default.
  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] v);
    if ((v >= TIME_W'(T_MIN)) && (v <= TIME_W'(T_MAX))) return v;
    return TIME_W'(T_DEF);
  endfunction

  // Next state, shadow/committed updates, pulses and shared timer.
  always_comb begin
    state_nx    = state_q;
    cfg_nx      = cfg_q;
    users_nx    = users_q;
    sh_nx       = sh_q;
    sh_users_nx = sh_users_q;
    idx_nx      = idx_q;
    tries_nx    = tries_q;
    ok_nx       = 1'b0;
    err_nx      = 1'b0;
    discard     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (setup_on) begin
          state_nx    = ST_AUTH;
          sh_nx       = cfg_q;
          sh_users_nx = users_q;
          idx_nx      = '0;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q >= TMR_W'(LOCK_CYC - 1)) begin
          state_nx = ST_IDLE;
          tries_nx = '0;
        end
      end
      ST_SAVE: begin
        cfg_nx   = sh_q;
        users_nx = sh_users_q;
        ok_nx    = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        if (!setup_on || (digitos_valid && is_abort) || (timer_q >= TMR_W'(TIMEOUT_CYC - 1))) begin
          discard = 1'b1;
        end else if (digitos_valid) begin
          unique case (state_q)
            ST_AUTH: begin
              if (!is_empty && (digitos_value == cfg_q.senha_master)) begin
                state_nx = ST_BIP_EN;
                tries_nx = '0;
              end else begin
                err_nx   = 1'b1;
                tries_nx = tries_q + TRY_W'(1);
                if (tries_q >= TRY_W'(MAX_TRIES - 1)) state_nx = ST_LOCKOUT;
              end
            end
            ST_BIP_EN: begin
              if (is_empty) begin
                state_nx = ST_BIP_T;
              end else if (time_ok && (len == LEN_W'(1)) && (dec_val <= TIME_W'(1))) begin
                sh_nx.bip_status = dec_val[0];
                state_nx         = ST_BIP_T;
              end else begin
                err_nx = 1'b1;
              end
            end
            ST_BIP_T: begin
              if (is_empty) begin
                state_nx = ST_TRC_T;
              end else if (time_ok) begin
                sh_nx.bip_time = clamp_time(dec_val);
                state_nx       = ST_TRC_T;
              end else begin
                err_nx = 1'b1;
              end
            end
            ST_TRC_T: begin
              if (is_empty) begin
                state_nx = ST_MASTER;
              end else if (time_ok) begin
                sh_nx.tranca_aut_time = clamp_time(dec_val);
                state_nx              = ST_MASTER;
              end else begin
                err_nx = 1'b1;
              end
            end
            ST_MASTER: begin
              if (is_empty || pw_ok) begin
                if (!is_empty) sh_nx.senha_master = digitos_value;
                state_nx = ST_USER;
                idx_nx   = '0;
              end else begin
                err_nx = 1'b1;
              end
            end
            ST_USER: begin
              if (is_empty || pw_ok) begin
                if (!is_empty) sh_users_nx[idx_q] = digitos_value;
                if (idx_q == IDX_W'(N_USERS - 1)) state_nx = ST_SAVE;
                else                              idx_nx   = idx_q + IDX_W'(1);
              end else begin
                err_nx = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    if (discard) begin
      state_nx    = ST_IDLE;
      sh_nx       = cfg_q;
      sh_users_nx = users_q;
      idx_nx      = '0;
    end

    // Idle timer restarts on any step change or accepted entry; lockout ignores entries.
    if ((state_nx != state_q) || (idx_nx != idx_q) || (state_q == ST_IDLE))
      timer_nx = '0;
    else if (digitos_valid && (state_q != ST_LOCKOUT))
      timer_nx = '0;
    else
      timer_nx = timer_q + TMR_W'(1);
  end

  // Display image for the upcoming state, registered with it.
  always_comb begin
    bcd_nx     = '1;
    disp_en_nx = (state_nx != ST_IDLE);
    locked_nx  = (state_nx == ST_LOCKOUT);
    unique case (state_nx)
      ST_AUTH:    bcd_nx[5] = STEP_AUTH;
      ST_LOCKOUT: bcd_nx[5] = STEP_LOCK;
      ST_BIP_EN: begin
        bcd_nx[5] = STEP_BIP_EN;
        bcd_nx[0] = DIG_W'(sh_nx.bip_status);
      end
      ST_BIP_T: begin
        bcd_nx[5] = STEP_BIP_T;
        bcd_nx[1] = bcd_tens(sh_nx.bip_time);
        bcd_nx[0] = bcd_ones(sh_nx.bip_time);
      end
      ST_TRC_T: begin
        bcd_nx[5] = STEP_TRC_T;
        bcd_nx[1] = bcd_tens(sh_nx.tranca_aut_time);
        bcd_nx[0] = bcd_ones(sh_nx.tranca_aut_time);
      end
      ST_MASTER:  bcd_nx[5] = STEP_MASTER;
      ST_USER: begin
        bcd_nx[5] = STEP_USER;
        bcd_nx[4] = DIG_W'(idx_nx) + DIG_W'(1);
      end
      default: ;
    endcase
  end

  // All state and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cfg_q      <= CFG_DEF;
      users_q    <= USERS_DEF;
      sh_q       <= CFG_DEF;
      sh_users_q <= USERS_DEF;
      idx_q      <= '0;
      tries_q    <= '0;
      timer_q    <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
      disp_en_q  <= 1'b0;
      bcd_q      <= '1;
    end else begin
      state_q    <= state_nx;
      cfg_q      <= cfg_nx;
      users_q    <= users_nx;
      sh_q       <= sh_nx;
      sh_users_q <= sh_users_nx;
      idx_q      <= idx_nx;
      tries_q    <= tries_nx;
      timer_q    <= timer_nx;
      ok_q       <= ok_nx;
      err_q      <= err_nx;
      locked_q   <= locked_nx;
      disp_en_q  <= disp_en_nx;
      bcd_q      <= bcd_nx;
    end
  end

  assign display_en     = disp_en_q;
  assign bcd_pac        = bcd_q;
  assign data_setup_new = cfg_q;
  assign senha_user_new = users_q;
  assign data_setup_ok  = ok_q;
  assign setup_err      = err_q;
  assign setup_locked   = locked_q;

endmodule

// File: tb/tb_setup_cfg_ctrl.sv
// Scoreboard bench for setup_cfg_ctrl: commits are predicted and checked on each ok pulse.
module tb_setup_cfg_ctrl;
  import setup_cfg_ctrl_pkg::*;

  localparam int unsigned NU = 4;
  localparam int unsigned TO = 200;
  localparam int unsigned LK = 300;
  localparam int unsigned CW = 384;

  typedef struct packed {
    setup_cfg_t               cfg;
    senha_pac_t [NU-1:0]      users;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                setup_on;
  senha_pac_t          digitos_value;
  logic                digitos_valid;
  logic                display_en;
  bcd_pac_t            bcd_pac;
  setup_cfg_t          data_setup_new;
  senha_pac_t [NU-1:0] senha_user_new;
  logic                data_setup_ok;
  logic                setup_err;
  logic                setup_locked;

  exp_t                sb_q[$];
  exp_t                sb_e;
  int                  total = 0;
  int                  bad = 0;
  int                  err_cnt = 0;
  int                  ok_cnt = 0;
  int                  exp_err = 0;
  setup_cfg_t          def_cfg, m_cfg;
  senha_pac_t [NU-1:0] m_users;
  senha_pac_t          mal;
  int                  cnt;

  always #5 clk = ~clk;

  setup_cfg_ctrl #(
    .N_USERS(NU), .PW_MIN_LEN(4), .T_MIN(5), .T_MAX(60), .T_DEF(5),
    .MAX_TRIES(3), .TIMEOUT_CYC(TO), .LOCK_CYC(LK)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .setup_on       (setup_on),
    .digitos_value  (digitos_value),
    .digitos_valid  (digitos_valid),
    .display_en     (display_en),
    .bcd_pac        (bcd_pac),
    .data_setup_new (data_setup_new),
    .senha_user_new (senha_user_new),
    .data_setup_ok  (data_setup_ok),
    .setup_err      (setup_err),
    .setup_locked   (setup_locked)
  );

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic senha_pac_t pw(input logic [79:0] d, input int n);
    senha_pac_t r;
    r = '1;
    for (int i = 0; i < n; i++) r[i] = d[i*4 +: 4];
    return r;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input senha_pac_t v);
    digitos_value = v;
    digitos_valid = 1'b1;
    @(negedge clk);
    #1;
    digitos_valid = 1'b0;
    digitos_value = '1;
  endtask

  // Pulse monitor: counts errors, checks every commit against the scoreboard.
  always @(negedge clk) begin
    if (setup_err) err_cnt++;
    if (data_setup_ok) begin
      ok_cnt++;
      if (sb_q.size() == 0) begin
        chk("ok_unexpected", CW'(1), CW'(0));
      end else begin
        sb_e = sb_q.pop_front();
        chk("commit_cfg", CW'(data_setup_new), CW'(sb_e.cfg));
        chk("commit_users", CW'(senha_user_new), CW'(sb_e.users));
      end
    end
  end

  initial begin
    rst = 1'b0; setup_on = 1'b0; digitos_valid = 1'b0; digitos_value = '1;
    def_cfg = '{bip_status: 1'b1, bip_time: 7'd5, tranca_aut_time: 7'd5, senha_master: pw(80'h1234, 4)};
    m_cfg   = def_cfg;
    m_users = '1;
    cycles(3);
    chk("rst_disp_en", CW'(display_en), CW'(0));
    chk("rst_bcd", CW'(bcd_pac), CW'(24'hFFFFFF));
    chk("rst_ok", CW'(data_setup_ok), CW'(0));
    chk("rst_err", CW'(setup_err), CW'(0));
    chk("rst_locked", CW'(setup_locked), CW'(0));
    chk("rst_cfg", CW'(data_setup_new), CW'(def_cfg));
    chk("rst_users", CW'(senha_user_new), CW'(m_users));
    rst = 1'b1;
    cycles(2);

    // Default walk-through with all-empty entries.
    setup_on = 1'b1;
    cycles(2);
    chk("auth_disp", CW'(bcd_pac), CW'(24'h1FFFFF));
    chk("auth_en", CW'(display_en), CW'(1));
    send(pw(80'h1234, 4));
    chk("bip_en_disp", CW'(bcd_pac), CW'(24'h2FFFF1));
    send('1);
    chk("bip_t_disp", CW'(bcd_pac), CW'(24'h3FFF05));
    send('1);
    chk("trc_t_disp", CW'(bcd_pac), CW'(24'h4FFF05));
    send('1);
    chk("master_disp", CW'(bcd_pac), CW'(24'h5FFFFF));
    send('1);
    chk("user0_disp", CW'(bcd_pac), CW'(24'h61FFFF));
    send('1); send('1); send('1);
    chk("user3_disp", CW'(bcd_pac), CW'(24'h64FFFF));
    sb_q.push_back('{cfg: m_cfg, users: m_users});
    send('1);
    chk("save_disp", CW'(bcd_pac), CW'(24'hFFFFFF));
    setup_on = 1'b0;
    cycles(3);
    chk("ok_cnt_1", CW'(ok_cnt), CW'(1));
    chk("idle_disp_en", CW'(display_en), CW'(0));

    // Full edit with rejects and clamping.
    setup_on = 1'b1;
    cycles(2);
    send(pw(80'h1234, 4));
    send(pw(80'h2, 1)); exp_err++;
    chk("bip_bad_stay", CW'(bcd_pac), CW'(24'h2FFFF1));
    send(pw(80'h0, 1));
    chk("bip_t_after", CW'(bcd_pac), CW'(24'h3FFF05));
    send(pw(80'h45, 2));
    chk("trc_t_after", CW'(bcd_pac), CW'(24'h4FFF05));
    send(pw(80'h75, 2));
    chk("master_after", CW'(bcd_pac), CW'(24'h5FFFFF));
    send(pw(80'h12, 2)); exp_err++;
    chk("master_short_stay", CW'(bcd_pac), CW'(24'h5FFFFF));
    mal = '1; mal[1] = 4'h3;
    send(mal); exp_err++;
    chk("malformed_stay", CW'(bcd_pac), CW'(24'h5FFFFF));
    cycles(1);
    chk("err_cnt_a", CW'(err_cnt), CW'(exp_err));
    send(pw(80'h98765, 5));
    chk("user0_disp_b", CW'(bcd_pac), CW'(24'h61FFFF));
    send(pw(80'h1111, 4));
    chk("user1_disp_b", CW'(bcd_pac), CW'(24'h62FFFF));
    send('1); send('1);
    m_cfg = '{bip_status: 1'b0, bip_time: 7'd45, tranca_aut_time: 7'd5, senha_master: pw(80'h98765, 5)};
    m_users[0] = pw(80'h1111, 4);
    sb_q.push_back('{cfg: m_cfg, users: m_users});
    send('1);
    setup_on = 1'b0;
    cycles(3);
    chk("ok_cnt_2", CW'(ok_cnt), CW'(2));

    // Abort with '#' at user index 2.
    setup_on = 1'b1;
    cycles(2);
    send(pw(80'h98765, 5));
    repeat (6) send('1);
    chk("user2_disp", CW'(bcd_pac), CW'(24'h63FFFF));
    send(SENHA_ABORT);
    chk("abort_idle", CW'(display_en), CW'(0));
    setup_on = 1'b0;
    cycles(2);
    chk("abort_cfg", CW'(data_setup_new), CW'(m_cfg));
    chk("abort_users", CW'(senha_user_new), CW'(m_users));

    // setup_on drop on the same cycle as an entry at user index 2.
    setup_on = 1'b1;
    cycles(2);
    send(pw(80'h98765, 5));
    repeat (6) send('1);
    digitos_value = pw(80'h2222, 4); digitos_valid = 1'b1; setup_on = 1'b0;
    @(negedge clk); #1;
    digitos_valid = 1'b0; digitos_value = '1;
    chk("drop_idle", CW'(display_en), CW'(0));
    cycles(2);
    chk("drop_cfg", CW'(data_setup_new), CW'(m_cfg));
    chk("drop_users", CW'(senha_user_new), CW'(m_users));
    chk("ok_cnt_3", CW'(ok_cnt), CW'(2));
    chk("err_cnt_b", CW'(err_cnt), CW'(exp_err));

    // Inactivity timeout at TRC_T discards the shadow.
    setup_on = 1'b1;
    cycles(2);
    send(pw(80'h98765, 5));
    chk("bip_en_c", CW'(bcd_pac), CW'(24'h2FFFF0));
    send('1);
    send(pw(80'h30, 2));
    chk("trc_t_c", CW'(bcd_pac), CW'(24'h4FFF05));
    cycles(TO - 10);
    chk("pre_timeout", CW'(bcd_pac), CW'(24'h4FFF05));
    cycles(15);
    chk("post_timeout", CW'(bcd_pac), CW'(24'h1FFFFF));
    send(pw(80'h98765, 5));
    send('1);
    chk("shadow_discarded", CW'(bcd_pac), CW'(24'h3FFF45));
    send(SENHA_ABORT);
    setup_on = 1'b0;
    cycles(2);

    // Three wrong masters -> lockout of exactly LK cycles.
    setup_on = 1'b1;
    cycles(2);
    repeat (3) send(pw(80'h1234, 4));
    exp_err += 3;
    chk("locked_on", CW'(setup_locked), CW'(1));
    chk("lock_disp", CW'(bcd_pac), CW'(24'hEFFFFF));
    cnt = 0;
    while (setup_locked && cnt < 3 * LK) begin
      cnt++;
      if (cnt == 10) begin
        digitos_value = m_cfg.senha_master; digitos_valid = 1'b1;
      end else begin
        digitos_valid = 1'b0; digitos_value = '1;
      end
      if (cnt == 20) setup_on = 1'b0;
      @(negedge clk); #1;
    end
    digitos_valid = 1'b0;
    chk("lock_len", CW'(cnt), CW'(LK));
    chk("lock_exit_idle", CW'(display_en), CW'(0));
    chk("err_cnt_c", CW'(err_cnt), CW'(exp_err));
    setup_on = 1'b1;
    cycles(2);
    send(pw(80'h1234, 4)); exp_err++;
    chk("tries_cleared", CW'(setup_locked), CW'(0));
    chk("auth_retry", CW'(bcd_pac), CW'(24'h1FFFFF));
    send(pw(80'h98765, 5));
    chk("auth_after_lock", CW'(bcd_pac), CW'(24'h2FFFF0));

    // Async reset in the middle of user entry.
    repeat (4) send('1);
    send(pw(80'h5555, 4));
    chk("user1_disp_d", CW'(bcd_pac), CW'(24'h62FFFF));
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_cfg", CW'(data_setup_new), CW'(def_cfg));
    chk("mid_rst_users", CW'(senha_user_new), CW'({NU{SENHA_EMPTY}}));
    chk("mid_rst_disp", CW'(display_en), CW'(0));
    chk("mid_rst_bcd", CW'(bcd_pac), CW'(24'hFFFFFF));
    setup_on = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(2);

    chk("err_cnt_final", CW'(err_cnt), CW'(exp_err));
    chk("ok_cnt_final", CW'(ok_cnt), CW'(2));
    chk("sb_empty", CW'(sb_q.size()), CW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
